// File: rtl/cmp_pkg.sv
// Shared encodings for the arbitrated comparator: FSM states and requester IDs.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/comparator_nbit.sv
// Combinational unsigned magnitude comparator, full operand width.
module comparator_nbit #(
    parameter int N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    always_comb begin
        lt = (a < b);
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Two requesters share one comparator through a round-robin arbiter;
// every output is taken straight from a flop.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic         smaller,
    output logic         equal,
    output logic         greater
);

    state_t       state;
    state_t       state_nx;
    logic         last;
    logic         id_r;
    logic         win;
    logic         grant_go;
    logic [N-1:0] a_r;
    logic [N-1:0] b_r;
    logic         lt;
    logic         eq;
    logic         gt;

    comparator_nbit #(.N(N)) u_cmp (
        .a  (a_r),
        .b  (b_r),
        .lt (lt),
        .eq (eq),
        .gt (gt)
    );

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        state_nx = state;
        grant_go = 1'b0;
        win      = ID_REQ0;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = ID_REQ1;
        end
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_go = 1'b1;
                    state_nx = CMP;
                end
            end
            CMP:     state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            smaller <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            last    <= ID_REQ1;
            id_r    <= ID_REQ0;
        end else begin
            state <= state_nx;
            gnt0  <= grant_go && (win == ID_REQ0);
            gnt1  <= grant_go && (win == ID_REQ1);
            busy  <= (state_nx != IDLE);
            done  <= (state == CMP);
            if (grant_go) begin
                a_r  <= (win == ID_REQ1) ? a1 : a0;
                b_r  <= (win == ID_REQ1) ? b1 : b0;
                last <= win;
                id_r <= win;
            end
            if (state == CMP) begin
                smaller <= lt;
                equal   <= eq;
                greater <= gt;
                done_id <= id_r;
            end
        end
    end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter with a cycle-countdown reference model.
module tb_cmp_share_arbiter;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1;
    logic [N-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, done, done_id, smaller, equal, greater;

    int tests  = 0;
    int fails  = 0;
    logic started = 1'b0;

    cmp_share_arbiter #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .smaller (smaller),
        .equal   (equal),
        .greater (greater)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cnt counts cycles left in the current transaction.
    int   cnt;
    logic m_last, m_id;
    logic m_gnt0, m_gnt1, m_busy, m_done, m_done_id, m_lt, m_eq, m_gt;
    logic [N-1:0] m_a, m_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt = 0; m_last = 1'b1; m_id = 1'b0;
            m_gnt0 = 0; m_gnt1 = 0; m_busy = 0; m_done = 0;
            m_done_id = 0; m_lt = 0; m_eq = 0; m_gt = 0;
            m_a = '0; m_b = '0;
        end else if (cnt == 0) begin
            m_done = 0; m_gnt0 = 0; m_gnt1 = 0; m_busy = 0;
            if (req0 || req1) begin
                if (req0 && req1) m_id = !m_last;
                else              m_id = req1;
                m_last = m_id;
                m_a = m_id ? a1 : a0;
                m_b = m_id ? b1 : b0;
                m_gnt0 = !m_id;
                m_gnt1 = m_id;
                m_busy = 1;
                cnt = 2;
            end
        end else if (cnt == 2) begin
            m_gnt0 = 0; m_gnt1 = 0; m_done = 1;
            m_done_id = m_id;
            m_lt = m_a < m_b; m_eq = m_a == m_b; m_gt = m_a > m_b;
            cnt = 1;
        end else begin
            m_done = 0; m_busy = 0;
            cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            check("gnt0",    gnt0,    m_gnt0);
            check("gnt1",    gnt1,    m_gnt1);
            check("busy",    busy,    m_busy);
            check("done",    done,    m_done);
            check("done_id", done_id, m_done_id);
            check("smaller", smaller, m_lt);
            check("equal",   equal,   m_eq);
            check("greater", greater, m_gt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One request from requester id; checks grant, then result, then return to idle.
    task automatic single(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic es, input logic ee, input logic eg);
        if (id) begin req1 = 1; a1 = a; b1 = b; end
        else    begin req0 = 1; a0 = a; b0 = b; end
        step(1);
        check(id ? "s_gnt1" : "s_gnt0", id ? gnt1 : gnt0, 1);
        req0 = 0; req1 = 0;
        step(1);
        check("s_done",    done,    1);
        check("s_done_id", done_id, id);
        check("s_smaller", smaller, es);
        check("s_equal",   equal,   ee);
        check("s_greater", greater, eg);
        step(1);
        check("s_idle", busy, 0);
    endtask

    task automatic pulse_reset();
        reset = 1;
        step(1);
        reset = 0;
        step(1);
    endtask

    initial begin
        logic [3:0] ids;
        int         ndone;
        int         tdone [4];
        reset = 1; req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step(2);
        reset = 0;
        started = 1;
        step(1);
        check("rst_outputs", {gnt0, gnt1, busy, done, done_id, smaller, equal, greater}, 0);

        single(0, 12'd5, 12'd99, 1, 0, 0);

        // Tie straight after reset: requester 0 first, requester 1 three cycles later.
        pulse_reset();
        req0 = 1; a0 = 12'd66; b0 = 12'd66;
        req1 = 1; a1 = 12'd100; b1 = 12'd47;
        step(1);
        check("tie_gnt0", {gnt0, gnt1}, 2'b10);
        req0 = 0;
        step(1);
        check("tie_first", {done, done_id, equal}, 3'b101);
        step(2);
        check("tie_gnt1", {gnt0, gnt1}, 2'b01);
        req1 = 0;
        step(1);
        check("tie_second", {done, done_id, greater}, 3'b111);
        step(1);

        // Both held for 12 cycles: alternate service, one done every 3 cycles.
        req0 = 1; a0 = 12'd1; b0 = 12'd2;
        req1 = 1; a1 = 12'd3; b1 = 12'd3;
        ids = '0; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (done) begin
                if (ndone < 4) begin
                    ids[ndone] = done_id;
                    tdone[ndone] = i;
                end
                ndone++;
            end
        end
        req0 = 0; req1 = 0;
        check("rr_count", ndone, 4);
        check("rr_ids", ids, 4'b1010);
        check("rr_period", tdone[1] - tdone[0], 3);
        check("rr_period2", tdone[3] - tdone[2], 3);
        step(2);

        single(0, 12'd4095, 12'd0, 0, 0, 1);
        single(1, 12'd0, 12'd4095, 1, 0, 0);
        single(0, 12'd0, 12'd0, 0, 1, 0);

        // Reset during CMP abandons the operation.
        req1 = 1; a1 = 12'd9; b1 = 12'd3;
        step(1);
        check("abort_gnt1", gnt1, 1);
        req1 = 0;
        #1 reset = 1;
        #1;
        check("abort_zero", {gnt0, gnt1, busy, done, done_id, smaller, equal, greater}, 0);
        step(1);
        reset = 0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (done) ndone++;
        end
        check("abort_nodone", ndone, 0);
        single(1, 12'd7, 12'd8, 1, 0, 0);

        // Operands change with no request: results hold, block stays idle.
        a0 = 12'd900; b0 = 12'd1; a1 = 12'd2; b1 = 12'd2;
        step(3);
        check("hold_results", {done_id, smaller, equal, greater}, 4'b1100);
        check("hold_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
